// File: rtl/pool_bram_reader.sv
// Streams a contiguous BRAM segment (base_addr, rd_len) out as a valid/ready stream,
// hiding the 1-cycle read latency. Optional stall counter: POOL_BRAM_RD_STALL_CNT_EN.
module pool_bram_reader #(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(SRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           rd_len,
  output logic                  bram_en,
  output logic [AW-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
`ifdef POOL_BRAM_RD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SRAM_DEPTH - 1);
  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nx;
  logic [AW-1:0]          addr_r;
  logic [AW:0]            remaining_r;
  logic                   inflight_r;
  logic                   inflight_last_r;
  logic [1:0]             count_r;
  logic [DATA_WIDTH-1:0]  slot0_data_r;
  logic [DATA_WIDTH-1:0]  slot1_data_r;
  logic                   slot0_last_r;
  logic                   slot1_last_r;
  logic                   valid_s;
  logic                   pop_s;
  logic                   accept_s;
  logic                   issue_s;
  logic [1:0]             occ_s;

  assign valid_s  = (count_r != 2'd0);
  assign pop_s    = valid_s & m_ready;
  assign accept_s = (state_r == IDLE) & start;
  assign occ_s    = count_r + {1'b0, inflight_r};

  // Issue decision: a read may only start if its word is guaranteed a buffer slot.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == READ) && (remaining_r != LEN_ZERO)) begin
      if (occ_s < 2'd2) begin
        issue_s = 1'b1;
      end else if ((occ_s == 2'd2) && pop_s) begin
        issue_s = 1'b1;
      end else begin
        issue_s = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = (rd_len == LEN_ZERO) ? DONE : READ;
        end else begin
          state_nx = IDLE;
        end
      end
      READ: begin
        if (issue_s && (remaining_r == LEN_ONE)) begin
          state_nx = DRAIN;
        end else begin
          state_nx = READ;
        end
      end
      DRAIN: begin
        if (pop_s && slot0_last_r) begin
          state_nx = DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; stream outputs come straight from the buffer head registers.
  always_comb begin
    bram_en   = issue_s;
    bram_addr = addr_r;
    m_valid   = valid_s;
    m_data    = slot0_data_r;
    m_last    = slot0_last_r;
    busy      = (state_r == READ) || (state_r == DRAIN);
    done      = (state_r == DONE);
  end

  // Address/length counters and the in-flight read tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r          <= ADDR_ZERO;
      remaining_r     <= LEN_ZERO;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r      <= base_addr;
        remaining_r <= rd_len;
      end else if (issue_s) begin
        addr_r      <= (addr_r == LAST_ADDR) ? ADDR_ZERO : (addr_r + ADDR_ONE);
        remaining_r <= remaining_r - LEN_ONE;
      end else begin
        addr_r      <= addr_r;
        remaining_r <= remaining_r;
      end
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (remaining_r == LEN_ONE);
    end
  end

  // Two-entry buffer; slot0 is always the head. Push with count==2 cannot occur.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r      <= 2'd0;
      slot0_data_r <= {DATA_WIDTH{1'b0}};
      slot1_data_r <= {DATA_WIDTH{1'b0}};
      slot0_last_r <= 1'b0;
      slot1_last_r <= 1'b0;
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_data_r <= bram_dout;
            slot0_last_r <= inflight_last_r;
          end else begin
            slot1_data_r <= bram_dout;
            slot1_last_r <= inflight_last_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_data_r <= slot1_data_r;
          slot0_last_r <= slot1_last_r;
          count_r      <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_data_r <= bram_dout;
            slot0_last_r <= inflight_last_r;
          end else begin
            slot0_data_r <= slot1_data_r;
            slot0_last_r <= slot1_last_r;
            slot1_data_r <= bram_dout;
            slot1_last_r <= inflight_last_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

`ifdef POOL_BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where the consumer held off valid data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (accept_s) begin
      stall_cnt_r <= 16'h0000;
    end else if (valid_s && !m_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
